// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and widths for the int8 dot-product sequencer
package mlp_pkg;

    localparam int MLP_LANES  = 4;
    localparam int MLP_LANE_W = 8;
    localparam int MLP_ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mlp_state_e;

endpackage

// File: rtl/mlp_mac4.sv
// rtl/mlp_mac4.sv - combinational 4-lane signed int8 multiply-accumulate
module mlp_mac4
    import mlp_pkg::*;
(
    input  logic [MLP_LANES*MLP_LANE_W-1:0] a,
    input  logic [MLP_LANES*MLP_LANE_W-1:0] b,
    input  logic [MLP_ACC_W-1:0]            sum_in,
    output logic [MLP_ACC_W-1:0]            sum_out
);

    logic [MLP_ACC_W-1:0] lane_ext [MLP_LANES];

    for (genvar i = 0; i < MLP_LANES; i++) begin : g_lane
        logic signed [2*MLP_LANE_W-1:0] prod;
        assign prod        = $signed(a[i*MLP_LANE_W +: MLP_LANE_W]) * $signed(b[i*MLP_LANE_W +: MLP_LANE_W]);
        assign lane_ext[i] = MLP_ACC_W'(prod);
    end

    // Everything wraps modulo 2^32; no overflow is tracked.
    always_comb begin
        sum_out = sum_in;
        for (int i = 0; i < MLP_LANES; i++) begin
            sum_out = sum_out + lane_ext[i];
        end
    end

endmodule

// File: rtl/mlp_dot_sequencer.sv
// rtl/mlp_dot_sequencer.sv - job FSM driving mlp_mac4; MLP_SEQ_RELU_EN clamps negative results to zero
module mlp_dot_sequencer
    import mlp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [MLP_ACC_W-1:0] bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MLP_ACC_W-1:0] res_data,
    output logic                 busy
);

    mlp_state_e           state;
    logic [MLP_ACC_W-1:0] acc;
    logic [MLP_ACC_W-1:0] mac_sum;
    logic [LEN_W-1:0]     cnt;

    mlp_mac4 u_mac (
        .a       (in_a),
        .b       (in_b),
        .sum_in  (acc),
        .sum_out (mac_sum)
    );

    // Handshake outputs are registered alongside the state so neither depends on in_valid/res_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= bias;
                        busy <= 1'b1;
                        if (len != '0) begin
                            cnt      <= len;
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= mac_sum;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MLP_SEQ_RELU_EN
    assign res_data = acc[MLP_ACC_W-1] ? '0 : acc;
`else
    assign res_data = acc;
`endif

endmodule

// File: tb/tb_mlp_dot_sequencer.sv
// tb/tb_mlp_dot_sequencer.sv - randomized scoreboard bench for mlp_dot_sequencer
module tb_mlp_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;

    mlp_dot_sequencer #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ja [$];
    logic [31:0] jb [$];
    int          stall_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Reference: signed byte products summed in 32-bit int arithmetic (wraps naturally).
    function automatic logic [31:0] model(input logic [31:0] bi);
        int  acc;
        byte sa;
        byte sb;
        acc = int'(bi);
        foreach (ja[k]) begin
            for (int l = 0; l < 4; l++) begin
                sa = ja[k][8*l +: 8];
                sb = jb[k][8*l +: 8];
                acc += int'(sa) * int'(sb);
            end
        end
`ifdef MLP_SEQ_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return 32'(acc);
    endfunction

    task automatic run_job(input int n, input logic [31:0] bi, input int mode, input int stall,
                           input int abort_after, input bit use_exp, input logic [31:0] exp_v);
        logic [31:0] e;
        int          idx;
        int          cyc;
        bit          v;
        e = use_exp ? exp_v : model(bi);
        if (abort_after < 0) exp_q.push_back(e);
        stall_req = stall;
        start    = 1'b1;
        len      = n[7:0];
        bias     = bi;
        in_valid = 1'($urandom_range(0, 1));
        in_a     = $urandom;
        in_b     = $urandom;
        @(negedge clk);
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        if (n == 0) begin
            chk1("zero_len_res_valid", res_valid, 1'b1);
            chk1("zero_len_in_ready", in_ready, 1'b0);
        end else begin
            chk1("in_ready_after_start", in_ready, 1'b1);
        end
        idx = 0;
        cyc = 0;
        while (idx < n) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_a     = v ? ja[idx] : $urandom;
            in_b     = v ? jb[idx] : $urandom;
            start    = (mode == 2) && ($urandom_range(0, 5) == 0);
            len      = 8'($urandom);
            bias     = $urandom;
            chk1("in_ready_accum", in_ready, 1'b1);
            if (in_ready !== 1'b1) break;
            @(negedge clk);
            cyc++;
            if (v) idx++;
            if (v && idx == abort_after) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                start    = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_res_valid", res_valid, 1'b0);
                chk1("abort_in_ready", in_ready, 1'b0);
                chk("abort_res_data", res_data, 32'h0);
                return;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (n != 0) begin
            chk1("res_valid_after_last", res_valid, 1'b1);
            chk1("in_ready_after_last", in_ready, 1'b0);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = $urandom;
            in_b     = $urandom;
            start    = ($urandom_range(0, 3) == 0);
            len      = 8'($urandom);
            bias     = $urandom;
            @(negedge clk);
            cyc++;
            chk1("in_ready_outside_accum", in_ready, 1'b0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk1("job_complete_busy", busy, 1'b0);
        chk1("job_complete_res_valid", res_valid, 1'b0);
    endtask

    bit          holding = 1'b0;
    int          stall_cnt = 0;
    logic [31:0] hold_data = '0;

    // Monitor: stalls res_ready per job, checks stability while stalled, pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            res_ready = 1'b0;
            holding   = 1'b0;
        end else if (res_ready) begin
            res_ready = 1'b0;
            chk1("res_valid_drop_after_take", res_valid, 1'b0);
        end else if (res_valid) begin
            if (!holding) begin
                holding   = 1'b1;
                stall_cnt = stall_req;
                hold_data = res_data;
            end else begin
                chk("res_data_stable", res_data, hold_data);
            end
            if (stall_cnt == 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=0x%08h required=none", res_data);
                end else begin
                    chk("result", res_data, exp_q.pop_front());
                end
                res_ready = 1'b1;
                holding   = 1'b0;
            end else begin
                stall_cnt--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] relu_exp;
        int          n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("reset_in_ready", in_ready, 1'b0);
        chk1("reset_res_valid", res_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk("reset_res_data", res_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);

        ja = '{32'h0A0A0A0A};
        jb = '{32'h0A0A0A0A};
        run_job(1, 32'd3, 0, 0, -1, 1'b1, 32'h00000193);

        ja = '{32'hFFFFFFFF, 32'h7F7F7F7F};
        jb = '{32'h01010101, 32'h02020202};
        run_job(2, 32'd0, 0, 1, -1, 1'b1, 32'h000003F4);

`ifdef MLP_SEQ_RELU_EN
        relu_exp = 32'h00000000;
`else
        relu_exp = 32'hFFFFFFFC;
`endif
        ja = '{32'hFFFFFFFF};
        jb = '{32'h01010101};
        run_job(1, 32'd0, 0, 0, -1, 1'b1, relu_exp);

        ja.delete();
        jb.delete();
        run_job(0, 32'd7, 0, 0, -1, 1'b1, 32'd7);

        ja = '{32'h01010101, 32'h01010101, 32'h01010101};
        jb = '{32'h01010101, 32'h01010101, 32'h01010101};
        run_job(3, 32'd5, 1, 5, -1, 1'b1, 32'd17);

        ja = '{32'h01000000};
        jb = '{32'h01000000};
        run_job(1, 32'hFFFFFFFF, 2, 0, -1, 1'b1, 32'h00000000);

        ja = '{$urandom, $urandom, $urandom};
        jb = '{$urandom, $urandom, $urandom};
        run_job(3, $urandom, 0, 0, 1, 1'b0, 32'h0);

        ja = '{32'h0A0A0A0A};
        jb = '{32'h0A0A0A0A};
        run_job(1, 32'd3, 0, 2, -1, 1'b1, 32'h00000193);

        for (int j = 0; j < 40; j++) begin
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            ja.delete();
            jb.delete();
            for (int k = 0; k < n; k++) begin
                ja.push_back($urandom);
                jb.push_back($urandom);
            end
            run_job(n, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), -1, 1'b0, 32'h0);
        end

        ja.delete();
        jb.delete();
        for (int k = 0; k < 255; k++) begin
            ja.push_back($urandom);
            jb.push_back($urandom);
        end
        run_job(255, $urandom, 0, 1, -1, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mlp_dot_sequencer.md
# mlp_dot_sequencer

Drives the 4-lane int8 MAC datapath of the ML accelerator. It accepts a job (vector length plus a 32-bit bias) and consumes a valid/ready stream of packed operand word pairs. Each beat goes through a 4-lane multiply-accumulate, and the running sum is chained back as the next partial sum. After the last beat it presents the 32-bit dot-product result on a valid/ready output.

## Interface
- `LEN_W`, 8: width of the job length field; maximum vector length is 2^LEN_W−1 beats.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request pulse; sampled only in IDLE.
- `len`  in  LEN_W  number of operand beats in the job; sampled with `start`.
- `bias`  in  32  initial accumulator value; sampled with `start`.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  sequencer can accept a beat.
- `in_a`  in  32  four int8 lanes: lane i = bits [8i+7:8i].
- `in_b`  in  32  four int8 lanes, same packing.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  32  dot-product result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `start`=1 with `len`≠0: acc←`bias`, cnt←`len`, go to ACCUM.
  - `start`=1 with `len`=0: acc←`bias`, go directly to DONE.
  - `start`=0: stay in IDLE.
- ACCUM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready`.
  - On acceptance: acc←acc + Σ(i=0..3) sext(a_i)·sext(b_i), and cnt←cnt−1.
  - When the accepted beat has cnt==1, go to DONE.
  - `in_valid`=0 holds state (bubbles allowed).
- DONE:
  - `res_valid`=1 and `res_data`=acc (or the ReLU value, see Configuration).
  - On `res_valid`&&`res_ready`, go to IDLE.
  - `res_data` is stable while `res_valid`=1 and `res_ready`=0.
- Arithmetic:
  - Lane products are signed 8×8→16 bits, sign-extended to 32.
  - The 4-lane sum and the accumulation are two's complement and wrap modulo 2^32; there is no overflow flag.
- `start` outside IDLE is ignored, with no queuing.
- Operand beats presented outside ACCUM are not accepted (`in_ready`=0).

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `busy`=0.
- Reset asserted mid-job aborts the job. Outputs return to reset values on the next edge, and no result is emitted.
- `start` accepted at edge N: `busy`=1 and `in_ready`=1 from cycle N+1 (`len`≠0).
- Last beat accepted at edge M: `res_valid`=1 in cycle M+1, and `in_ready`=0 in that same cycle.
- With `len`=0: `res_valid`=1 in the cycle after `start`.
- Result taken at edge K: IDLE in cycle K+1. A new `start` may be accepted at edge K+1, so the turnaround is one IDLE cycle per job.
- Throughput: one beat per clock in ACCUM with no stalls. The MAC is combinational into the acc register.
- `in_ready` and `res_valid` are registered-state decodes only, with no combinational path from `in_valid` or `res_ready`.

## Configuration
- `MLP_SEQ_RELU_EN`:
  - Defined: `res_data` = (acc[31] ? 0 : acc), i.e. ReLU on the final result only. Intermediate accumulation is unaffected.
  - Undefined: `res_data` = acc unchanged.

## Structure
- Shared package `mlp_pkg`:
  - state enum (IDLE/ACCUM/DONE)
  - `MLP_LANES`=4
  - `MLP_LANE_W`=8
  - `MLP_ACC_W`=32
- One sub-module, `mlp_mac4`: combinational. Inputs are `a`[31:0], `b`[31:0] and `sum_in`[31:0]; output is `sum_out`[31:0] = `sum_in` + Σ signed lane products. The sequencer instantiates it with `sum_in`=acc.
- Top module: FSM, down-counter, accumulator register and handshake decode.

## Test plan
- **Single beat:** `start`, `len`=1, `bias`=3, a=b=0x0A0A0A0A → `res_data`=0x00000193 (4·100+3), `res_valid` one cycle after the beat.
- **Signed lanes:** `len`=2, `bias`=0, beats (0xFFFFFFFF, 0x01010101) and (0x7F7F7F7F, 0x02020202) → 0x000003F4 (−4+1016). With `MLP_SEQ_RELU_EN` and only the first beat (`len`=1) → 0x00000000; without the macro → 0xFFFFFFFC.
- **Zero length:** `len`=0, `bias`=7 → `res_valid` the cycle after `start`, `res_data`=7, no beat consumed.
- **Backpressure and bubbles:**
  - `len`=3, `in_valid` toggling 1,0,1,0,1 with a=b=0x01010101 → result 12 plus bias.
  - `res_ready` held 0 for 5 cycles → `res_data` stable and `res_valid` held.
- **Ignored start / wrap:** `start` pulsed during ACCUM → no effect. `bias`=0xFFFFFFFF with one beat a=b=0x01000000 → 0x00000000 (wrap).
- **Reset mid-job:** `rst` after 1 of 3 beats → next cycle IDLE, `busy`=0, `res_valid`=0. A subsequent fresh job computes correctly.
